sap_clock_ctrl: RTL and testbench

Clock-enable sequencer for the SAP-1 CPU, driven by the outputs of three debouncer instances (step, mode and clear pushbuttons) plus the CPU HLT signal.
- Produces single-cycle `clk_en` pulses for the CPU datapath in manual single-step mode or free-running divided mode.
- Produces a one-cycle CPU clear pulse.
- Freezes the CPU on HLT until cleared.
- Sits between the board-level debouncers and the CPU core, on the single FPGA clock.

---
 rtl/sap_ctrl_pkg.sv | 13 +
 rtl/sap_clock_ctrl_rise_detect.sv | 25 ++
 rtl/sap_clock_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sap_clock_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sap_ctrl_pkg.sv
// rtl/sap_ctrl_pkg.sv - shared types and constants for the SAP-1 clock controller
package sap_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_MANUAL = 2'b00,
    CTRL_RUN    = 2'b01,
    CTRL_HALTED = 2'b10
  } ctrl_state_t;

  // Button history starts "pressed" so a button held through reset is not seen as a press.
  localparam logic HIST_RESET_VAL = 1'b1;

endpackage

// File: rtl/sap_clock_ctrl_rise_detect.sv
// rtl/sap_clock_ctrl_rise_detect.sv - rise_detect: 1-bit history register producing a press strobe
module rise_detect
  import sap_ctrl_pkg::*;
#(
  parameter logic RESET_VAL = HIST_RESET_VAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic press
);

  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= RESET_VAL;
    end else begin
      hist <= d;
    end
  end

  assign press = d & ~hist;

endmodule

// File: rtl/sap_clock_ctrl.sv
// rtl/sap_clock_ctrl.sv - SAP-1 clock-enable sequencer (MANUAL/RUN/HALTED)
// Optional step auto-repeat is enabled by defining SAP_CLK_STEP_REPEAT_EN.
module sap_clock_ctrl
  import sap_ctrl_pkg::*;
#(
  parameter int DIV_COUNT     = 50_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_pb,
  input  logic mode_pb,
  input  logic clr_pb,
  input  logic hlt,
  output logic clk_en,
  output logic cpu_clr,
  output logic run_mode,
  output logic halted
);

  localparam int               CNT_W   = $clog2(DIV_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_COUNT - 1);

  if (DIV_COUNT < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("sap_clock_ctrl: DIV_COUNT must be >= 2 and repeat timings >= 1");
  end

  ctrl_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             clk_en_nxt, cpu_clr_nxt;
  logic             step_press, mode_press, clr_press;
  logic             hlt_mask;
  logic             hlt_act;

`ifdef SAP_CLK_STEP_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic             rep_active, rep_active_nxt;
  logic             rep_periodic, rep_periodic_nxt;
  logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
  logic             rep_due;

  assign rep_due = rep_periodic ? (rep_cnt == REP_PERIOD_LAST) : (rep_cnt == REP_DELAY_LAST);
`endif

  rise_detect #(.RESET_VAL(HIST_RESET_VAL)) u_step_rd (
    .clk(clk), .rst_n(rst_n), .d(step_pb), .press(step_press)
  );
  rise_detect #(.RESET_VAL(HIST_RESET_VAL)) u_mode_rd (
    .clk(clk), .rst_n(rst_n), .d(mode_pb), .press(mode_press)
  );
  rise_detect #(.RESET_VAL(HIST_RESET_VAL)) u_clr_rd (
    .clk(clk), .rst_n(rst_n), .d(clr_pb), .press(clr_press)
  );

  // hlt is masked for one edge after a clear so the CPU has time to drop it.
  assign hlt_act = hlt & ~hlt_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CTRL_MANUAL;
      cnt      <= '0;
      clk_en   <= 1'b0;
      cpu_clr  <= 1'b0;
      run_mode <= 1'b0;
      halted   <= 1'b0;
      hlt_mask <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clk_en   <= clk_en_nxt;
      cpu_clr  <= cpu_clr_nxt;
      run_mode <= (state_nxt == CTRL_RUN);
      halted   <= (state_nxt == CTRL_HALTED);
      hlt_mask <= clr_press;
    end
  end

`ifdef SAP_CLK_STEP_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_active   <= 1'b0;
      rep_periodic <= 1'b0;
      rep_cnt      <= '0;
    end else begin
      rep_active   <= rep_active_nxt;
      rep_periodic <= rep_periodic_nxt;
      rep_cnt      <= rep_cnt_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    if (clr_press) begin
      state_nxt = CTRL_MANUAL;
    end else if (hlt_act && state != CTRL_HALTED) begin
      state_nxt = CTRL_HALTED;
    end else begin
      case (state)
        CTRL_MANUAL: if (mode_press) state_nxt = CTRL_RUN;
        CTRL_RUN:    if (mode_press) state_nxt = CTRL_MANUAL;
        CTRL_HALTED: state_nxt = CTRL_HALTED;
        default:     state_nxt = CTRL_MANUAL;
      endcase
    end
  end

  // Every path that does not explicitly keep counting leaves the counters cleared.
  always_comb begin
    clk_en_nxt  = 1'b0;
    cpu_clr_nxt = 1'b0;
    cnt_nxt     = '0;
`ifdef SAP_CLK_STEP_REPEAT_EN
    rep_active_nxt   = 1'b0;
    rep_periodic_nxt = 1'b0;
    rep_cnt_nxt      = '0;
`endif
    if (clr_press) begin
      cpu_clr_nxt = 1'b1;
    end else if (hlt_act && state != CTRL_HALTED) begin
      clk_en_nxt = 1'b0;
    end else begin
      case (state)
        CTRL_MANUAL: begin
          if (!mode_press) begin
            if (step_press) begin
              clk_en_nxt = 1'b1;
`ifdef SAP_CLK_STEP_REPEAT_EN
              rep_active_nxt = 1'b1;
`endif
            end
`ifdef SAP_CLK_STEP_REPEAT_EN
            else if (rep_active && step_pb) begin
              rep_active_nxt = 1'b1;
              if (rep_due) begin
                clk_en_nxt       = 1'b1;
                rep_periodic_nxt = 1'b1;
              end else begin
                rep_cnt_nxt      = rep_cnt + 1'b1;
                rep_periodic_nxt = rep_periodic;
              end
            end
`endif
          end
        end
        CTRL_RUN: begin
          if (!mode_press) begin
            if (cnt == CNT_MAX) begin
              clk_en_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        default: clk_en_nxt = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_clock_ctrl.sv
// tb/tb_sap_clock_ctrl.sv - scoreboard bench for sap_clock_ctrl (DIV_COUNT=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
module tb_sap_clock_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step_pb = 1'b1;
  logic mode_pb = 1'b0;
  logic clr_pb = 1'b0;
  logic hlt = 1'b0;
  logic clk_en, cpu_clr, run_mode, halted;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_en_q[$];
  int exp_clr_q[$];

  sap_clock_ctrl #(
    .DIV_COUNT(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .step_pb(step_pb),
    .mode_pb(mode_pb),
    .clr_pb(clr_pb),
    .hlt(hlt),
    .clk_en(clk_en),
    .cpu_clr(cpu_clr),
    .run_mode(run_mode),
    .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the head of its queue; stale heads are missed pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_en_q.size() > 0 && exp_en_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL clk_en_missing: no pulse seen, expected at cycle %0d (now %0d)", exp_en_q[0], cyc);
        void'(exp_en_q.pop_front());
      end
      if (clk_en) begin
        checks++;
        if (exp_en_q.size() > 0 && exp_en_q[0] == cyc) begin
          void'(exp_en_q.pop_front());
        end else begin
          errors++;
          $display("FAIL clk_en_pulse: pulse at cycle %0d, expected cycle %0d", cyc,
                   (exp_en_q.size() > 0) ? exp_en_q[0] : -1);
        end
      end
      if (exp_clr_q.size() > 0 && exp_clr_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL cpu_clr_missing: no pulse seen, expected at cycle %0d (now %0d)", exp_clr_q[0], cyc);
        void'(exp_clr_q.pop_front());
      end
      if (cpu_clr) begin
        checks++;
        if (exp_clr_q.size() > 0 && exp_clr_q[0] == cyc) begin
          void'(exp_clr_q.pop_front());
        end else begin
          errors++;
          $display("FAIL cpu_clr_pulse: pulse at cycle %0d, expected cycle %0d", cyc,
                   (exp_clr_q.size() > 0) ? exp_clr_q[0] : -1);
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the selected buttons high for exactly one cycle.
  task automatic press(input bit s, input bit m, input bit c);
    if (s) step_pb = 1'b1;
    if (m) mode_pb = 1'b1;
    if (c) clr_pb = 1'b1;
    @(negedge clk);
    if (s) step_pb = 1'b0;
    if (m) mode_pb = 1'b0;
    if (c) clr_pb = 1'b0;
  endtask

  initial begin
    int t;

    // Reset with step held
    wait_n(2);
    chk("reset_clk_en", clk_en, 1'b0);
    chk("reset_cpu_clr", cpu_clr, 1'b0);
    chk("reset_run_mode", run_mode, 1'b0);
    chk("reset_halted", halted, 1'b0);
    rst_n = 1'b1;
    wait_n(10);
    chk("held_step_no_pulse", clk_en, 1'b0);
    step_pb = 1'b0;
    wait_n(2);

    // Single step press
    t = cyc;
    exp_en_q.push_back(t + 1);
    press(1, 0, 0);
    wait_n(4);

    // RUN mode divider, step ignored, exit with no pulse
    t = cyc;
    exp_en_q.push_back(t + 5);
    exp_en_q.push_back(t + 9);
    exp_en_q.push_back(t + 13);
    press(0, 1, 0);
    chk("run_mode_enter", run_mode, 1'b1);
    wait_n(1);
    press(1, 0, 0);
    wait_n(11);
    press(0, 1, 0);
    chk("run_mode_exit", run_mode, 1'b0);
    wait_n(8);

    // hlt at the edge a RUN pulse is due
    t = cyc;
    press(0, 1, 0);
    wait_n(3);
    hlt = 1'b1;
    wait_n(1);
    chk("halt_entered", halted, 1'b1);
    chk("halt_run_mode_low", run_mode, 1'b0);
    for (int i = 0; i < 10; i++) begin
      press(1, 0, 0);
      press(0, 1, 0);
    end
    wait_n(1);
    chk("halt_ignores_buttons", halted, 1'b1);
    chk("halt_ignores_mode", run_mode, 1'b0);

    // clr out of HALTED with hlt still high, hlt dropped one cycle later
    t = cyc;
    exp_clr_q.push_back(t + 1);
    press(0, 0, 1);
    chk("clr_leaves_halt", halted, 1'b0);
    chk("clr_to_manual", run_mode, 1'b0);
    wait_n(1);
    chk("hlt_masked_after_clr", halted, 1'b0);
    hlt = 1'b0;
    wait_n(3);
    chk("no_rehalt", halted, 1'b0);

    // Same-edge clr+mode in RUN, then same-edge hlt+step in MANUAL
    t = cyc;
    press(0, 1, 0);
    chk("run_before_clr", run_mode, 1'b1);
    wait_n(1);
    exp_clr_q.push_back(t + 3);
    press(0, 1, 1);
    chk("clr_beats_mode_run", run_mode, 1'b0);
    chk("clr_beats_mode_halt", halted, 1'b0);
    wait_n(2);
    hlt = 1'b1;
    step_pb = 1'b1;
    wait_n(1);
    hlt = 1'b0;
    step_pb = 1'b0;
    chk("hlt_beats_step", halted, 1'b1);
    wait_n(1);
    t = cyc;
    exp_clr_q.push_back(t + 1);
    press(0, 0, 1);
    chk("clr_exit_halt", halted, 1'b0);
    wait_n(3);

    // Held step: single pulse, or auto-repeat when enabled
    t = cyc;
    exp_en_q.push_back(t + 1);
`ifdef SAP_CLK_STEP_REPEAT_EN
    exp_en_q.push_back(t + 9);
    exp_en_q.push_back(t + 12);
    exp_en_q.push_back(t + 15);
    exp_en_q.push_back(t + 18);
`endif
    step_pb = 1'b1;
    wait_n(20);
    step_pb = 1'b0;
    wait_n(6);

    chk("clk_en_queue_drained", (exp_en_q.size() == 0), 1'b1);
    chk("cpu_clr_queue_drained", (exp_clr_q.size() == 0), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
